ni_resend_packetizer: RTL and testbench
=======================================

Name: ni_resend_packetizer

Overview:
- Sequential successor to the NI header chunk selector.
- Captures one response header, stores it for retransmission, and serializes it into HEADER_FLITS typed flits followed by pl_len payload flits.
- Uses a valid/ready handshake toward the switch.
- Sits in the initiator/target NI between the response builder and the output flit port.
- A resend request replays the stored header; the payload is re-supplied by the source.

Parameters:
- FLIT_WIDTH, 32, total flit width including type field.
- FTYPEWD, 2, flit type field width; ftype occupies the MSBs.
- BASE_WIDTH, FLIT_WIDTH-FTYPEWD, data bits per flit.
- HEADER_FLITS, 3, header flits per packet (>=1).
- HEADER_LENGTH, 80, header bits; must be <= HEADER_FLITS*BASE_WIDTH; unused upper bits are sent as zero.
- MAX_PAYLOAD, 16, maximum payload flits per packet.
- LENW, 5, width of pl_len; must hold MAX_PAYLOAD.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- hdr_valid  in  1  new header offered
- hdr_ready  out  1  header accepted when hdr_valid&hdr_ready
- hdr_data  in  HEADER_LENGTH  header bits
- pl_len  in  LENW  payload flit count, sampled with the header; 0..MAX_PAYLOAD
- pl_valid  in  1  payload chunk valid
- pl_data  in  BASE_WIDTH  payload chunk
- pl_ready  out  1  payload chunk consumed
- resend_req  in  1  single-cycle pulse: replay the stored packet
- flit_out  out  FLIT_WIDTH  {ftype, data}
- flit_valid  out  1  flit_out valid
- flit_ready  in  1  downstream accepts flit
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; hdr_ready=1.
  - flit_valid=0, pl_ready=0, busy=0, flit_out=0.
  - Stored header and pl_len cleared; resend_pend=0.
- ftype encoding: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, HEADTAIL=2'b11.
- IDLE:
  - hdr_ready=1 only if resend_pend=0.
  - On hdr_valid&hdr_ready: store hdr_data and pl_len; cnt=0; next state HEADER.
  - If resend_pend=1: clear it, cnt=0, go to HEADER using the stored header and pl_len. resend_pend has priority over hdr_valid.
- HEADER:
  - flit_valid=1.
  - flit_out data = stored_header[BASE_WIDTH*cnt +: BASE_WIDTH], zero-padded.
  - ftype:
    - cnt==0: HEAD.
    - Last header flit with stored pl_len==0: TAIL.
    - HEADER_FLITS==1 and pl_len==0: HEADTAIL.
    - Otherwise BODY.
  - On flit_ready: cnt++. At cnt==HEADER_FLITS-1:
    - Go to PAYLOAD with cnt=0 if pl_len>0.
    - Go to IDLE if pl_len==0.
  - Without flit_ready: flit_out and flit_valid hold stable. No change while stalled.
- PAYLOAD:
  - Combinational passthrough: flit_valid=pl_valid; pl_ready=flit_ready; data=pl_data.
  - ftype=TAIL on flit cnt==pl_len-1, else BODY.
  - On pl_valid&flit_ready: cnt++. The last flit goes to IDLE.
- pl_ready=0 outside PAYLOAD.
- Latency:
  - Header accepted in cycle N → first flit valid in cycle N+1.
  - Back-to-back packets: one IDLE cycle minimum between the tail and the next head.
- resend_req:
  - In IDLE it sets resend_pend; the replay head appears 2 cycles later.
  - In HEADER/PAYLOAD it sets resend_pend; the replay starts after the current tail.
  - Multiple pulses before service collapse to one replay.
  - resend_req with no packet ever stored (since reset) is ignored.
- pl_len > MAX_PAYLOAD: clamp to MAX_PAYLOAD.
- Reset mid-packet: immediate abort, flit_valid=0. The stored header is lost.

Decomposition:
- Shared package/include (ni_parameters): ftype encodings, FTYPEWD, state encoding (IDLE=0, HEADER=1, PAYLOAD=2).
- Sub-module ni_header_chunk_mux: combinational selection of header chunk cnt from the stored header, zero-padding the last chunk.
- Counter, FSM and handshake live in the top module.

Test Plan:
- Defaults, hdr_data=80'h1234_5678_9ABC_DEF0_1122, pl_len=2, flit_ready=1, pl_valid=1 (pl_data 30'h1, 30'h2) → 5 flits: HEAD, BODY, BODY (header chunks 0..2), BODY 30'h1, TAIL 30'h2; then IDLE with busy=0.
- pl_len=0 → 3 flits HEAD, BODY, TAIL; pl_ready never asserted. Repeat with HEADER_FLITS=1 → single HEADTAIL flit.
- flit_ready low for 4 cycles on header flit 1 → flit_out stable and flit_valid=1 throughout; sequence completes unchanged; no flit duplicated or dropped.
- resend_req pulsed during PAYLOAD of packet A while hdr_valid offers packet B → after A's tail, A's header is replayed before B; hdr_ready=0 until the replay starts.
- reset_n asserted low in the middle of the second header flit → flit_valid=0 asynchronously; after release, hdr_ready=1 and a subsequent resend_req produces no flits.
- pl_len=20 with MAX_PAYLOAD=16 → exactly 16 payload flits, the 16th typed TAIL.

Source files
------------

// File: rtl/ni_resend_packetizer_pkg.sv
// rtl/ni_resend_packetizer_pkg.sv - shared flit type, FSM state and sizing helpers for the NI packetizer
package ni_resend_packetizer_pkg;

  localparam int FTYPEWD = 2;

  typedef enum logic [FTYPEWD-1:0] {
    FT_BODY     = 2'b00,
    FT_TAIL     = 2'b01,
    FT_HEAD     = 2'b10,
    FT_HEADTAIL = 2'b11
  } ftype_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ni_resend_packetizer_chunk_mux.sv
// rtl/ni_resend_packetizer_chunk_mux.sv - selects header chunk sel, zero-padding bits beyond the header
module ni_header_chunk_mux #(
  parameter int BASE_WIDTH    = 30,
  parameter int HEADER_FLITS  = 3,
  parameter int HEADER_LENGTH = 80,
  parameter int CNTW          = 5
) (
  input  logic [HEADER_LENGTH-1:0] hdr,
  input  logic [CNTW-1:0]          sel,
  output logic [BASE_WIDTH-1:0]    chunk
);

  localparam int PADW = HEADER_FLITS * BASE_WIDTH;

  logic [PADW-1:0] padded;

  always_comb begin
    padded = '0;
    padded[HEADER_LENGTH-1:0] = hdr;
    chunk = '0;
    for (int i = 0; i < HEADER_FLITS; i++) begin
      if (sel == CNTW'(i)) chunk = padded[i*BASE_WIDTH +: BASE_WIDTH];
    end
  end

endmodule

// File: rtl/ni_resend_packetizer.sv
// rtl/ni_resend_packetizer.sv - stores one response header and serializes header plus payload flits, with replay on request
module ni_resend_packetizer
  import ni_resend_packetizer_pkg::*;
#(
  parameter int FLIT_WIDTH    = 32,
  parameter int BASE_WIDTH    = FLIT_WIDTH - FTYPEWD,
  parameter int HEADER_FLITS  = 3,
  parameter int HEADER_LENGTH = 80,
  parameter int MAX_PAYLOAD   = 16,
  parameter int LENW          = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     hdr_valid,
  output logic                     hdr_ready,
  input  logic [HEADER_LENGTH-1:0] hdr_data,
  input  logic [LENW-1:0]          pl_len,
  input  logic                     pl_valid,
  input  logic [BASE_WIDTH-1:0]    pl_data,
  output logic                     pl_ready,
  input  logic                     resend_req,
  output logic [FLIT_WIDTH-1:0]    flit_out,
  output logic                     flit_valid,
  input  logic                     flit_ready,
  output logic                     busy
);

  localparam int CNTW = max_int(LENW, $clog2(HEADER_FLITS + 1));

  state_e                   state, state_nxt;
  logic [CNTW-1:0]          cnt, cnt_nxt;
  logic [HEADER_LENGTH-1:0] stored_hdr;
  logic [LENW-1:0]          stored_len;
  logic                     resend_pend;
  logic                     have_pkt;
  logic                     load_hdr;
  logic                     service;
  logic [LENW-1:0]          len_clamped;
  logic [CNTW-1:0]          len_c;
  logic                     hdr_last;
  logic                     pl_last;
  logic [BASE_WIDTH-1:0]    chunk;
  logic [BASE_WIDTH-1:0]    fdata;
  ftype_e                   ftype;

  assign len_clamped = (pl_len > LENW'(MAX_PAYLOAD)) ? LENW'(MAX_PAYLOAD) : pl_len;
  assign len_c       = CNTW'(stored_len);
  assign hdr_last    = (cnt == CNTW'(HEADER_FLITS - 1));
  assign pl_last     = (cnt == len_c - CNTW'(1));

  ni_header_chunk_mux #(
    .BASE_WIDTH    (BASE_WIDTH),
    .HEADER_FLITS  (HEADER_FLITS),
    .HEADER_LENGTH (HEADER_LENGTH),
    .CNTW          (CNTW)
  ) u_chunk_mux (
    .hdr   (stored_hdr),
    .sel   (cnt),
    .chunk (chunk)
  );

  // A request landing on the service cycle is absorbed into the replay being started.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      stored_hdr  <= '0;
      stored_len  <= '0;
      resend_pend <= 1'b0;
      have_pkt    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load_hdr) begin
        stored_hdr <= hdr_data;
        stored_len <= len_clamped;
        have_pkt   <= 1'b1;
      end
      if (service) resend_pend <= 1'b0;
      else if (resend_req && (have_pkt || load_hdr)) resend_pend <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_hdr  = 1'b0;
    service   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (resend_pend) begin
          service   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_HEADER;
        end else if (hdr_valid) begin
          load_hdr  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (flit_ready) begin
          if (hdr_last) begin
            cnt_nxt   = '0;
            state_nxt = (stored_len == '0) ? ST_IDLE : ST_PAYLOAD;
          end else begin
            cnt_nxt = cnt + CNTW'(1);
          end
        end
      end
      ST_PAYLOAD: begin
        if (pl_valid && flit_ready) begin
          if (pl_last) begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt + CNTW'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    hdr_ready  = (state == ST_IDLE) && !resend_pend;
    busy       = (state != ST_IDLE);
    flit_valid = 1'b0;
    pl_ready   = 1'b0;
    ftype      = FT_BODY;
    fdata      = '0;
    case (state)
      ST_HEADER: begin
        flit_valid = 1'b1;
        fdata      = chunk;
        if (hdr_last && stored_len == '0) ftype = (HEADER_FLITS == 1) ? FT_HEADTAIL : FT_TAIL;
        else if (cnt == '0)               ftype = FT_HEAD;
      end
      ST_PAYLOAD: begin
        flit_valid = pl_valid;
        pl_ready   = flit_ready;
        fdata      = pl_data;
        ftype      = pl_last ? FT_TAIL : FT_BODY;
      end
      default: ;
    endcase
  end

  assign flit_out = {ftype, fdata};

endmodule

// File: tb/tb_ni_resend_packetizer.sv
// tb/tb_ni_resend_packetizer.sv - directed table-driven bench for the resend packetizer
module tb_ni_resend_packetizer;

  typedef struct packed {
    logic [79:0]      hdr;
    logic [4:0]       len;
    int               stall_at;
    int               stall_n;
    int               n;
    logic [4:0][31:0] exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        hdr_valid = 1'b0, hdr_valid1 = 1'b0;
  logic        hdr_ready, hdr_ready1;
  logic [79:0] hdr_data = '0;
  logic [4:0]  pl_len = '0;
  logic        pl_valid = 1'b1;
  logic [29:0] pl_data = 30'd1;
  logic        pl_ready, pl_ready1;
  logic        resend_req = 1'b0;
  logic [31:0] flit_out, flit_out1;
  logic        flit_valid, flit_valid1;
  logic        flit_ready = 1'b1;
  logic        busy, busy1;

  int tests = 0;
  int fails = 0;
  logic [31:0] got[$];
  logic [31:0] got1[$];
  int   pl_count = 0;
  int   pl_idx = 0;
  int   src_len = 1;
  bit   pl_hs = 0, hdr_acc = 0, hdr_acc1 = 0, pl1_seen = 0;
  int   acc_idx = -1;
  vec_t vecs[4];

  localparam logic [79:0] H0 = 80'h1234_5678_9ABC_DEF0_1122;
  localparam logic [79:0] HB = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

  always #5 clock = ~clock;

  ni_resend_packetizer u_dut (
    .clock(clock), .reset_n(reset_n), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_data(hdr_data), .pl_len(pl_len), .pl_valid(pl_valid), .pl_data(pl_data),
    .pl_ready(pl_ready), .resend_req(resend_req), .flit_out(flit_out),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .busy(busy)
  );

  ni_resend_packetizer #(.HEADER_FLITS(1), .HEADER_LENGTH(24)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .hdr_valid(hdr_valid1), .hdr_ready(hdr_ready1),
    .hdr_data(hdr_data[23:0]), .pl_len(pl_len), .pl_valid(pl_valid), .pl_data(pl_data),
    .pl_ready(pl_ready1), .resend_req(resend_req), .flit_out(flit_out1),
    .flit_valid(flit_valid1), .flit_ready(flit_ready), .busy(busy1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [79:0] h, input logic [4:0] l, input int sa, input int sn,
                              input int n, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3, input logic [31:0] e4);
    vec_t v;
    v.hdr = h; v.len = l; v.stall_at = sa; v.stall_n = sn; v.n = n;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
    return v;
  endfunction

  // Observe at the falling edge what the next rising edge will commit.
  task automatic sample_edge();
    @(negedge clock);
    if (flit_valid && flit_ready) got.push_back(flit_out);
    if (flit_valid1 && flit_ready) got1.push_back(flit_out1);
    if (pl_ready1) pl1_seen = 1;
    pl_hs = pl_valid && pl_ready;
    if (pl_hs) pl_count++;
    if (hdr_valid && hdr_ready) begin hdr_acc = 1; acc_idx = got.size(); end
    if (hdr_valid1 && hdr_ready1) hdr_acc1 = 1;
  endtask

  task automatic advance_edge();
    @(posedge clock);
    #1;
    if (pl_hs) begin
      pl_idx  = (pl_idx + 1 == src_len) ? 0 : pl_idx + 1;
      pl_data = 30'(pl_idx + 1);
    end
    if (hdr_acc)  begin hdr_valid = 0;  hdr_acc = 0;  end
    if (hdr_acc1) begin hdr_valid1 = 0; hdr_acc1 = 0; end
  endtask

  task automatic start_pkt(input logic [79:0] h, input logic [4:0] l, input int slen, input bit offer);
    got.delete();
    pl_count = 0; pl_idx = 0; pl_data = 30'd1; src_len = slen;
    hdr_data = h; pl_len = l; hdr_valid = offer;
  endtask

  task automatic run_to(input int n, input int stall_at, input int stall_n, input logic [31:0] stall_exp);
    int left = stall_n;
    for (int c = 0; c < 200; c++) begin
      flit_ready = !(got.size() == stall_at && left > 0);
      sample_edge();
      if (!flit_ready) begin
        chk("stall_valid", 64'(flit_valid), 64'd1);
        chk("stall_flit", 64'(flit_out), 64'(stall_exp));
        left--;
      end
      advance_edge();
      if (got.size() >= n && !busy) return;
    end
    tests++; fails++;
    $display("FAIL timeout: got %0d flits, wanted %0d", got.size(), n);
  endtask

  initial begin
    vecs[0] = mk(H0, 5'd2, -1, 0, 5, 32'h9EF01122, 32'h19E26AF3, 32'h00012345, 32'h00000001, 32'h40000002);
    vecs[1] = mk(H0, 5'd0, -1, 0, 3, 32'h9EF01122, 32'h19E26AF3, 32'h40012345, 32'h0, 32'h0);
    vecs[2] = mk(H0, 5'd2,  1, 4, 5, 32'h9EF01122, 32'h19E26AF3, 32'h00012345, 32'h00000001, 32'h40000002);
    vecs[3] = mk('0, 5'd1, -1, 0, 4, 32'h80000000, 32'h0, 32'h0, 32'h40000001, 32'h0);

    #1;
    chk("rst_hdr_ready", 64'(hdr_ready), 64'd1);
    chk("rst_flit_valid", 64'(flit_valid), 64'd0);
    chk("rst_pl_ready", 64'(pl_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flit_out", 64'(flit_out), 64'd0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    for (int r = 0; r < 4; r++) begin
      start_pkt(vecs[r].hdr, vecs[r].len, int'(vecs[r].len), 1);
      run_to(vecs[r].n, vecs[r].stall_at, vecs[r].stall_n,
             vecs[r].exp[(vecs[r].stall_at >= 0) ? vecs[r].stall_at : 0]);
      chk($sformatf("row%0d_count", r), 64'(got.size()), 64'(vecs[r].n));
      for (int i = 0; i < vecs[r].n && i < got.size(); i++)
        chk($sformatf("row%0d_flit%0d", r, i), 64'(got[i]), 64'(vecs[r].exp[i]));
      chk($sformatf("row%0d_payload", r), 64'(pl_count), 64'(vecs[r].len));
      chk($sformatf("row%0d_busy", r), 64'(busy), 64'd0);
      chk($sformatf("row%0d_hdr_ready", r), 64'(hdr_ready), 64'd1);
    end

    // Replay from IDLE: head appears two cycles after the pulse.
    start_pkt('0, 5'd1, 1, 0);
    resend_req = 1;
    sample_edge();
    advance_edge();
    resend_req = 0;
    sample_edge();
    chk("idle_rs_valid1", 64'(flit_valid), 64'd0);
    chk("idle_rs_hdr_ready", 64'(hdr_ready), 64'd0);
    advance_edge();
    sample_edge();
    chk("idle_rs_valid2", 64'(flit_valid), 64'd1);
    chk("idle_rs_head", 64'(flit_out), 64'h80000000);
    advance_edge();
    run_to(4, -1, 0, '0);
    chk("idle_rs_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("idle_rs_flit%0d", i), 64'(got[i]), 64'(vecs[3].exp[i]));

    // Two pulses during packet A while B waits: exactly one replay of A, then B.
    start_pkt(H0, 5'd2, 2, 1);
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      resend_req = (got.size() == 1 || got.size() == 3);
      if (got.size() == 3 && !hdr_valid) begin
        hdr_data = HB; hdr_valid = 1; acc_idx = -1;
      end
      sample_edge();
      advance_edge();
    end
    resend_req = 0;
    run_to(15, -1, 0, '0);
    repeat (6) begin sample_edge(); advance_edge(); end
    chk("rs_b_count", 64'(got.size()), 64'd15);
    chk("rs_b_accept_at", 64'(acc_idx), 64'd10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      chk($sformatf("rs_a_flit%0d", i), 64'(got[i]), 64'(vecs[0].exp[i % 5]));
    if (got.size() >= 15) begin
      chk("rs_b_head", 64'(got[10]), 64'hBFFFFFFF);
      chk("rs_b_body1", 64'(got[11]), 64'h3FFFFFFF);
      chk("rs_b_body2", 64'(got[12]), 64'h000FFFFF);
      chk("rs_b_tail", 64'(got[14]), 64'h40000002);
    end

    // Oversized pl_len clamps to 16 payload flits.
    start_pkt(H0, 5'd20, 16, 1);
    run_to(19, -1, 0, '0);
    chk("clamp_count", 64'(got.size()), 64'd19);
    chk("clamp_payload", 64'(pl_count), 64'd16);
    if (got.size() >= 19) begin
      chk("clamp_15", 64'(got[17]), 64'h0000000F);
      chk("clamp_tail", 64'(got[18]), 64'h40000010);
    end

    // Single header flit, no payload: one HEADTAIL flit.
    got1.delete(); pl1_seen = 0;
    hdr_data = H0; pl_len = 5'd0; hdr_valid1 = 1;
    for (int c = 0; c < 20; c++) begin
      sample_edge();
      advance_edge();
      if (got1.size() >= 1 && !busy1) break;
    end
    chk("ht_count", 64'(got1.size()), 64'd1);
    if (got1.size() >= 1) chk("ht_flit", 64'(got1[0]), 64'hC0F01122);
    chk("ht_pl_ready", 64'(pl1_seen), 64'd0);

    // Reset during the second header flit.
    start_pkt(H0, 5'd2, 2, 1);
    for (int c = 0; c < 20 && got.size() < 1; c++) begin sample_edge(); advance_edge(); end
    #2 reset_n = 1'b0;
    hdr_valid = 0;
    #1;
    chk("rst_mid_valid", 64'(flit_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    chk("rst_mid_hdr_ready", 64'(hdr_ready), 64'd1);
    got.delete(); got1.delete();
    resend_req = 1;
    sample_edge();
    advance_edge();
    resend_req = 0;
    repeat (6) begin sample_edge(); advance_edge(); end
    chk("rst_resend_flits", 64'(got.size()), 64'd0);
    chk("rst_resend_flits1", 64'(got1.size()), 64'd0);
    chk("rst_resend_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
